ps2_key_event_ctrl: RTL and testbench
=====================================

# ps2_key_event_ctrl

Sequences the raw PS/2 scan-code byte stream from the PS/2 deserializer into complete key events (make/break, extended) and buffers them for the step sequencer's input logic. It resolves the E0, F0 and E1 prefix sequences with a state machine and drops keyboard housekeeping bytes. It delivers events through a small FIFO with a valid/ready handshake, and flags overflow and protocol errors.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of 2, ≥2
- TIMEOUT_CYCLES, 2500000, idle cycles (50 ms at 50 MHz) before a partial prefix sequence is abandoned; only used with PS2_TIMEOUT_EN
- CLOCK_50  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- byte_in  in  8  scan-code byte, valid only while byte_valid=1
- byte_valid  in  1  single-cycle strobe, one per received byte
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  8  head event scan code (final byte of sequence)
- ev_ext  out  1  head event was E0- or E1-prefixed
- ev_break  out  1  head event is a key release (F0-prefixed)
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- err_cnt  out  8  saturating count of protocol errors and timeouts

## Operation
- Housekeeping bytes are discarded in every state without changing state: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF.
- FSM states and transitions:
  - IDLE: E0→EXT; F0→BRK; E1→PAUSE (skip counter=0); any other byte→emit {code, ext=0, brk=0}.
  - EXT: F0→EXT_BRK; E0→EXT (no error); E1→PAUSE with err_cnt+1; any other byte→emit {ext=1, brk=0}→IDLE.
  - BRK: any non-prefix byte→emit {brk=1, ext=0}→IDLE; E0→EXT with err_cnt+1; F0→BRK with err_cnt+1; E1→PAUSE with err_cnt+1.
  - EXT_BRK: any non-prefix byte→emit {ext=1, brk=1}→IDLE; any prefix byte→err_cnt+1, then handled as in IDLE.
  - PAUSE: consumes the next 7 bytes of any value, housekeeping bytes included. On the 7th byte, emit {code=0xE1, ext=1, brk=0}→IDLE.
- Event word is 10 bits, {ext, brk, code}, written to the FIFO tail.
- FIFO behaviour:
  - ev_valid = (count≠0); ev_code/ev_ext/ev_break reflect the head entry combinationally.
  - Pop on ev_valid & ev_ready.
- Full: an emit with no simultaneous pop is dropped and overflow sets. The FSM still advances normally.
- Full with simultaneous emit and pop: both occur, count is unchanged, no overflow.
- Empty with ev_ready high: no pop; pointers hold.
- Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- err_cnt saturates at 255. overflow and err_cnt clear only on Reset.

## Timing
- Reset values: FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0x00, ev_ext=0, ev_break=0, overflow=0, err_cnt=0.
- Reset takes effect at the next rising edge. It overrides byte_valid and ev_ready in the same cycle: no push, no pop, no count.
- Latency: a completing byte_valid in cycle N gives ev_valid=1 with that event at the head in cycle N+1, provided the FIFO was empty.
- A pop in cycle N presents the next entry, or ev_valid=0, in cycle N+1.
- One byte is processed per byte_valid. Back-to-back strobes in consecutive cycles are supported.
- overflow rises in the cycle after the dropped emit. err_cnt updates in the cycle after the offending byte.

## Configuration
- PS2_TIMEOUT_EN defined:
  - A counter resets on every byte_valid and increments each cycle while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES−1, the FSM returns to IDLE and err_cnt increments (saturating). No event is emitted.
  - If byte_valid coincides with expiry, the byte wins: it is processed normally and there is no timeout.
- PS2_TIMEOUT_EN undefined: no counter is instantiated and TIMEOUT_CYCLES is ignored. A partial sequence waits indefinitely.

## Test plan
- Bytes 0x1C; then F0, 0x1C; ev_ready=1 → events {0x1C, ext0, brk0} then {0x1C, ext0, brk1}; each ev_valid appears one cycle after its final byte.
- Bytes E0, F0, 0x74 with FA inserted between E0 and F0 → single event {0x74, ext1, brk1}; FA is ignored; err_cnt=0.
- Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {0xE1, ext1, brk0}, emitted after the 8th byte.
- ev_ready=0, FIFO_DEPTH=4, 5 make codes 0x15..0x19 → 4 entries 0x15..0x18, overflow=1. Then ev_ready=1 with a new byte 0x1A arriving in the same cycle as the first pop → order 0x16, 0x17, 0x18, 0x1A after 0x15.
- Bytes F0, E0, 0x6B → err_cnt=1, event {0x6B, ext1, brk0}. Assert Reset mid-sequence after E0 → all outputs at reset values; next byte 0x6B gives {0x6B, ext0, brk0}.
- With PS2_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte E0, then 20 idle cycles, then 0x1C → err_cnt=1, event {0x1C, ext0, brk0}.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 scan-code to key-event sequencer with event FIFO; optional idle timeout via PS2_TIMEOUT_EN
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       overflow,
   output logic [7:0] err_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_PAUSE
   } state_t;

   state_t      state, state_nx;
   logic [2:0]  skip_cnt, skip_cnt_nx;
   logic        emit;
   logic [9:0]  emit_word;
   logic        err_inc;
   logic        timeout_hit;

   logic        is_e0, is_f0, is_e1, is_prefix, is_hk;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop;

   assign is_e0     = (byte_in == 8'hE0);
   assign is_f0     = (byte_in == 8'hF0);
   assign is_e1     = (byte_in == 8'hE1);
   assign is_prefix = is_e0 | is_f0 | is_e1;
   assign is_hk     = (byte_in == 8'h00) | (byte_in == 8'hAA) | (byte_in == 8'hEE) |
                      (byte_in == 8'hFA) | (byte_in == 8'hFE) | (byte_in == 8'hFF);

   // Where a prefix byte leads when it starts a fresh sequence
   function automatic state_t prefix_target(input logic [7:0] b);
      if (b == 8'hE0)
         return S_EXT;
      else if (b == 8'hF0)
         return S_BRK;
      else
         return S_PAUSE;
   endfunction

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_cnt;

   assign timeout_hit = (state != S_IDLE) && (to_cnt == TO_LAST);

   // Idle counter for abandoning a stalled partial sequence
   always_ff @(posedge CLOCK_50) begin
      if (Reset)
         to_cnt <= '0;
      else if (byte_valid || state == S_IDLE || timeout_hit)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TW'(1);
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit = 1'b0;
`endif

   // Sequencer state and pause-byte counter registers
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state    <= S_IDLE;
         skip_cnt <= 3'd0;
      end else begin
         state    <= state_nx;
         skip_cnt <= skip_cnt_nx;
      end
   end

   // Next-state decode: prefix resolution, event emission and error flagging
   always_comb begin
      state_nx    = state;
      skip_cnt_nx = skip_cnt;
      emit        = 1'b0;
      emit_word   = {2'b00, byte_in};
      err_inc     = 1'b0;
      if (byte_valid) begin
         if (state == S_PAUSE) begin
            // Pause sequence swallows 7 bytes verbatim, housekeeping included
            skip_cnt_nx = skip_cnt + 3'd1;
            if (skip_cnt == 3'd6) begin
               emit        = 1'b1;
               emit_word   = {1'b1, 1'b0, 8'hE1};
               state_nx    = S_IDLE;
               skip_cnt_nx = 3'd0;
            end
         end else if (!is_hk) begin
            case (state)
               S_IDLE: begin
                  if (is_prefix) begin
                     state_nx = prefix_target(byte_in);
                  end else begin
                     emit      = 1'b1;
                     emit_word = {2'b00, byte_in};
                  end
               end
               S_EXT: begin
                  if (is_f0) begin
                     state_nx = S_EXT_BRK;
                  end else if (is_e0) begin
                     state_nx = S_EXT;
                  end else if (is_e1) begin
                     state_nx = S_PAUSE;
                     err_inc  = 1'b1;
                  end else begin
                     emit      = 1'b1;
                     emit_word = {2'b10, byte_in};
                     state_nx  = S_IDLE;
                  end
               end
               S_BRK: begin
                  if (is_prefix) begin
                     state_nx = prefix_target(byte_in);
                     err_inc  = 1'b1;
                  end else begin
                     emit      = 1'b1;
                     emit_word = {2'b01, byte_in};
                     state_nx  = S_IDLE;
                  end
               end
               S_EXT_BRK: begin
                  if (is_prefix) begin
                     state_nx = prefix_target(byte_in);
                     err_inc  = 1'b1;
                  end else begin
                     emit      = 1'b1;
                     emit_word = {2'b11, byte_in};
                     state_nx  = S_IDLE;
                  end
               end
               default: state_nx = S_IDLE;
            endcase
         end
      end else if (timeout_hit) begin
         state_nx    = S_IDLE;
         skip_cnt_nx = 3'd0;
         err_inc     = 1'b1;
      end
   end

   assign full     = (count == DEPTH_CNT);
   assign ev_valid = (count != '0);
   assign pop      = ev_valid & ev_ready;
   assign push     = emit & (~full | pop);

   assign {ev_ext, ev_break, ev_code} = mem[rd_ptr];

   // Event FIFO storage; cleared on reset so the idle head reads as zero
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= 10'd0;
      end else if (push) begin
         mem[wr_ptr] <= emit_word;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag and saturating protocol error counter
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         overflow <= 1'b0;
         err_cnt  <= 8'd0;
      end else begin
         if (emit && full && !pop)
            overflow <= 1'b1;
         if (err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - directed self-checking bench for ps2_key_event_ctrl
module tb_ps2_key_event_ctrl;

   logic       CLOCK_50 = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid = 1'b0;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       overflow;
   logic [7:0] err_cnt;

   logic [10:0] head;
   assign head = {ev_valid, ev_ext, ev_break, ev_code};

   int checks = 0;
   int failures = 0;

   ps2_key_event_ctrl #(
      .FIFO_DEPTH(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .Reset(Reset),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_code(ev_code),
      .ev_ext(ev_ext),
      .ev_break(ev_break),
      .overflow(overflow),
      .err_cnt(err_cnt)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic pop_one();
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (head !== 11'h000) begin
         failures++;
         $display("FAIL reset_head got=%h exp=%h", head, 11'h000);
      end
      checks++;
      if ({overflow, err_cnt} !== 9'h000) begin
         failures++;
         $display("FAIL reset_status got=%h exp=%h", {overflow, err_cnt}, 9'h000);
      end
   endtask

   task automatic test_make_break();
      ev_ready = 1'b1;
      send(8'h1C);
      checks++;
      if (head !== {3'b100, 8'h1C}) begin
         failures++;
         $display("FAIL mb_make got=%h exp=%h", head, {3'b100, 8'h1C});
      end
      send(8'hF0);
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++;
         $display("FAIL mb_popped got=%b exp=0", ev_valid);
      end
      send(8'h1C);
      checks++;
      if (head !== {3'b101, 8'h1C}) begin
         failures++;
         $display("FAIL mb_break got=%h exp=%h", head, {3'b101, 8'h1C});
      end
      tick();
      send(8'hAA);
      send(8'h00);
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++;
         $display("FAIL mb_housekeeping got=%b exp=0", ev_valid);
      end
      ev_ready = 1'b0;
   endtask

   task automatic test_ext_break();
      send(8'hE0);
      send(8'hFA);
      send(8'hF0);
      send(8'h74);
      checks++;
      if (head !== {3'b111, 8'h74}) begin
         failures++;
         $display("FAIL eb_event got=%h exp=%h", head, {3'b111, 8'h74});
      end
      checks++;
      if (err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL eb_err got=%0d exp=0", err_cnt);
      end
      pop_one();
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++;
         $display("FAIL eb_single got=%b exp=0", ev_valid);
      end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8];
      seq[0] = 8'hE1; seq[1] = 8'h14; seq[2] = 8'h77; seq[3] = 8'hE1;
      seq[4] = 8'hF0; seq[5] = 8'h14; seq[6] = 8'hF0; seq[7] = 8'h77;
      for (int i = 0; i < 7; i++)
         send(seq[i]);
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++;
         $display("FAIL pause_early got=%b exp=0", ev_valid);
      end
      send(seq[7]);
      checks++;
      if (head !== {3'b110, 8'hE1}) begin
         failures++;
         $display("FAIL pause_event got=%h exp=%h", head, {3'b110, 8'hE1});
      end
      pop_one();
      checks++;
      if ({ev_valid, err_cnt} !== 9'h000) begin
         failures++;
         $display("FAIL pause_after got=%h exp=%h", {ev_valid, err_cnt}, 9'h000);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp [4];
      exp[0] = 8'h16; exp[1] = 8'h17; exp[2] = 8'h18; exp[3] = 8'h1A;
      for (int i = 0; i < 4; i++)
         send(8'h15 + 8'(i));
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_not_yet got=%b exp=0", overflow);
      end
      send(8'h19);
      checks++;
      if ({overflow, head} !== {1'b1, 3'b100, 8'h15}) begin
         failures++;
         $display("FAIL ovf_set got=%h exp=%h", {overflow, head}, {1'b1, 3'b100, 8'h15});
      end
      byte_in    = 8'h1A;
      byte_valid = 1'b1;
      ev_ready   = 1'b1;
      tick();
      byte_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (head !== {3'b100, exp[i]}) begin
            failures++;
            $display("FAIL ovf_order%0d got=%h exp=%h", i, head, {3'b100, exp[i]});
         end
         tick();
      end
      ev_ready = 1'b0;
      checks++;
      if ({ev_valid, overflow} !== 2'b01) begin
         failures++;
         $display("FAIL ovf_drain got=%b exp=01", {ev_valid, overflow});
      end
   endtask

   task automatic test_errors();
      do_reset();
      send(8'hF0);
      send(8'hE0);
      checks++;
      if (err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL err_brk_e0 got=%0d exp=1", err_cnt);
      end
      send(8'h6B);
      checks++;
      if (head !== {3'b110, 8'h6B}) begin
         failures++;
         $display("FAIL err_event got=%h exp=%h", head, {3'b110, 8'h6B});
      end
      pop_one();
      send(8'hE0);
      send(8'hF0);
      send(8'hE0);
      send(8'h75);
      checks++;
      if ({err_cnt, head} !== {8'd2, 3'b110, 8'h75}) begin
         failures++;
         $display("FAIL err_extbrk got=%h exp=%h", {err_cnt, head}, {8'd2, 3'b110, 8'h75});
      end
      pop_one();
      send(8'h1C);
      send(8'hE0);
      Reset      = 1'b1;
      byte_in    = 8'h6B;
      byte_valid = 1'b1;
      ev_ready   = 1'b1;
      tick();
      Reset      = 1'b0;
      byte_valid = 1'b0;
      ev_ready   = 1'b0;
      checks++;
      if ({overflow, err_cnt, head} !== 20'h00000) begin
         failures++;
         $display("FAIL err_midreset got=%h exp=%h", {overflow, err_cnt, head}, 20'h00000);
      end
      send(8'h6B);
      checks++;
      if (head !== {3'b100, 8'h6B}) begin
         failures++;
         $display("FAIL err_after_reset got=%h exp=%h", head, {3'b100, 8'h6B});
      end
      pop_one();
   endtask

   task automatic test_timeout();
      do_reset();
      send(8'hE0);
      repeat (20) tick();
      send(8'h1C);
`ifdef PS2_TIMEOUT_EN
      checks++;
      if ({err_cnt, head} !== {8'd1, 3'b100, 8'h1C}) begin
         failures++;
         $display("FAIL timeout_abandon got=%h exp=%h", {err_cnt, head}, {8'd1, 3'b100, 8'h1C});
      end
`else
      checks++;
      if ({err_cnt, head} !== {8'd0, 3'b110, 8'h1C}) begin
         failures++;
         $display("FAIL timeout_wait got=%h exp=%h", {err_cnt, head}, {8'd0, 3'b110, 8'h1C});
      end
`endif
      pop_one();
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [5];
      seq[0] = 8'h11; seq[1] = 8'hF0; seq[2] = 8'h11; seq[3] = 8'hE0; seq[4] = 8'h12;
      for (int i = 0; i < 5; i++) begin
         byte_in    = seq[i];
         byte_valid = 1'b1;
         tick();
      end
      byte_valid = 1'b0;
      checks++;
      if (head !== {3'b100, 8'h11}) begin
         failures++;
         $display("FAIL b2b_first got=%h exp=%h", head, {3'b100, 8'h11});
      end
      pop_one();
      checks++;
      if (head !== {3'b101, 8'h11}) begin
         failures++;
         $display("FAIL b2b_second got=%h exp=%h", head, {3'b101, 8'h11});
      end
      pop_one();
      checks++;
      if (head !== {3'b110, 8'h12}) begin
         failures++;
         $display("FAIL b2b_third got=%h exp=%h", head, {3'b110, 8'h12});
      end
      pop_one();
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_empty got=%b exp=0", ev_valid);
      end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_ext_break();
      test_pause();
      test_overflow();
      test_errors();
      test_timeout();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
